// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counter with registered sync, blank and frame-stable mode outputs.
module vga_sync_gen #(
    parameter int H_VIEW  = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_VIEW  = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_mode,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       visible,
    output logic       new_line,
    output logic       new_frame,
    output logic [7:0] frame,
    output logic [7:0] mode
);

    localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VIEW);
    localparam logic [9:0] V_VIS    = 10'(V_VIEW);
    localparam logic [9:0] HS_START = 10'(H_VIEW + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VIEW + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIEW + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VIEW + V_FRONT + V_SYNC);

    logic       h_wrap;
    logic       v_wrap;
    logic       frame_start;
    logic [9:0] h_next;
    logic [9:0] v_next;

    // Decodes are computed from the next counter values so every registered
    // output lines up with the hpos/vpos it is presented alongside.
    always_comb begin
        h_wrap      = (hpos == H_LAST);
        v_wrap      = (vpos == V_LAST);
        frame_start = h_wrap && v_wrap;
        h_next      = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next      = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? 10'd0 : vpos + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos      <= 10'd0;
            vpos      <= 10'd0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            hblank    <= 1'b0;
            vblank    <= 1'b0;
            visible   <= 1'b1;
            new_line  <= 1'b0;
            new_frame <= 1'b0;
            frame     <= 8'd0;
            mode      <= 8'd0;
        end else begin
            hpos      <= h_next;
            vpos      <= v_next;
            hsync     <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync     <= !((v_next >= VS_START) && (v_next < VS_END));
            hblank    <= (h_next >= H_VIS);
            vblank    <= (v_next >= V_VIS);
            visible   <= (h_next < H_VIS) && (v_next < V_VIS);
            new_line  <= h_wrap;
            new_frame <= frame_start;
            if (frame_start) begin
                frame <= frame + 8'd1;
                mode  <= i_mode;
            end
        end
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL take parameter H_VIEW, default 640, visible pixels per line.
REQ-002 SHALL take parameter H_FRONT, default 16, horizontal front porch in clocks.
REQ-003 SHALL take parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL take parameter H_BACK, default 48, horizontal back porch in clocks.
REQ-005 SHALL take parameter V_VIEW, default 480, visible lines per frame.
REQ-006 SHALL take parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL take parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL take parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 clk  input  1  pixel clock; all state advances on its rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 i_mode  input  8  requested mode bits, sampled only at frame start.
REQ-012 hpos  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-013 vpos  output  10  current vertical count, 0..V_TOTAL-1.
REQ-014 hsync  output  1  horizontal sync, active low.
REQ-015 vsync  output  1  vertical sync, active low.
REQ-016 hblank  output  1  high when hpos >= H_VIEW.
REQ-017 vblank  output  1  high when vpos >= V_VIEW.
REQ-018 visible  output  1  high when hblank and vblank are both low.
REQ-019 new_line  output  1  one-clock pulse on the first clock of each line.
REQ-020 new_frame  output  1  one-clock pulse on the first clock of each frame.
REQ-021 frame  output  8  count of completed frames, modulo 256.
REQ-022 mode  output  8  frame-stable copy of i_mode.

Function
REQ-023 H_TOTAL SHALL be H_VIEW+H_FRONT+H_SYNC+H_BACK (800 by default), and V_TOTAL SHALL be V_VIEW+V_FRONT+V_SYNC+V_BACK (525 by default).
REQ-024 hpos SHALL increment by 1 every clock and SHALL wrap from H_TOTAL-1 to 0.
REQ-025 vpos SHALL increment by 1 only on the clock where hpos wraps, and SHALL wrap from V_TOTAL-1 to 0 when hpos also wraps.
REQ-026 hsync SHALL be low exactly for H_VIEW+H_FRONT <= hpos < H_VIEW+H_FRONT+H_SYNC (656..751 by default).
REQ-027 vsync SHALL be low exactly for V_VIEW+V_FRONT <= vpos < V_VIEW+V_FRONT+V_SYNC (490..491 by default).
REQ-028 Every output SHALL be driven from a flop, and all decoded outputs SHALL correspond to the hpos and vpos values presented in the same cycle (zero skew between counters and decodes).
REQ-029 new_line SHALL be high for exactly one clock when hpos=0 and the previous clock had hpos=H_TOTAL-1.
REQ-030 new_frame SHALL be high for exactly one clock when hpos=0, vpos=0 and the previous clock had hpos=H_TOTAL-1 and vpos=V_TOTAL-1.
  - When new_frame is high, new_line SHALL also be high.
REQ-031 On the clock that asserts new_frame, frame SHALL increment, wrapping from 255 to 0, and mode SHALL load the i_mode value sampled on the same edge.
REQ-032 mode SHALL hold constant for every other clock, regardless of i_mode changes.
REQ-033 Counter arithmetic SHALL be 10-bit unsigned, and parameter totals above 1024 are unsupported.

Reset
REQ-034 While reset is high, the following SHALL hold:
  - hpos=0, vpos=0, frame=0, mode=0.
  - hsync=1, vsync=1.
  - hblank=0, vblank=0, visible=1.
  - new_line=0, new_frame=0.
REQ-035 Assertion of reset mid-frame SHALL take effect immediately (asynchronously) without waiting for a clock edge.
REQ-036 The first rising clk edge after reset deassertion SHALL advance hpos to 1, and no new_line or new_frame pulse SHALL be generated for the reset-initialised (0,0) position.

Verification
REQ-037 Release reset and run 800 clocks -> hpos sequences 0..799 then 0; vpos steps 0->1 at the wrap; new_line pulses once, at the wrap clock.
REQ-038 Run one full frame of 420000 clocks -> hsync low for exactly 96 clocks per line (hpos 656..751); vsync low for exactly 1600 clocks (vpos 490..491); visible high for exactly 307200 clocks.
REQ-039 Run through the end of frame -> new_frame pulses once at the transition (799,524)->(0,0); frame goes 0->1; the new_line and new_frame pulses coincide.
REQ-040 Set i_mode=0xA5 mid-frame, then 0x3C one clock before the wrap -> mode stays 0x00 until the wrap, then becomes 0x3C and holds through the next frame despite i_mode toggling.
REQ-041 Run 256 frames -> frame wraps 255->0 on the 256th new_frame.
REQ-042 Assert reset asynchronously at hpos=700, vpos=300 -> all outputs take their REQ-034 values before the next clk edge; after release, hpos=1 on the first edge and no spurious pulses occur.
